// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with a circular return-address stack.
// Priority per edge: start gating, exception, stall, return, branch/call, sequential.
module pc_unit_ras #(
  parameter int unsigned          ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]    RESET_VEC   = '0,
  parameter int unsigned          INSTR_BYTES = 4,
  parameter int unsigned          RAS_DEPTH   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              pcEnable_i,
  input  logic              exc_i,
  input  logic [ADDR_W-1:0] exc_vec_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              call_i,
  input  logic              ret_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              ras_empty_o,
  output logic              ras_full_o,
  output logic              ras_ovf_o,
  output logic              ras_unf_o,
  output logic              misalign_o
);

  localparam int unsigned       PtrW    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned       CntW    = $clog2(RAS_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LowMask = ADDR_W'(INSTR_BYTES - 1);
  localparam logic [CntW-1:0]   CntMax  = CntW'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic              empty_q, full_q;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              mis_q, mis_d;

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] tgt_al;
  logic              tgt_mis;
  logic [PtrW-1:0]   top_idx;

  always_comb begin
    seq_pc  = pc_q + ADDR_W'(INSTR_BYTES);
    tgt_al  = br_target_i & ~LowMask;
    tgt_mis = |(br_target_i & LowMask);
    top_idx = ptr_q - PtrW'(1);

    pc_d    = pc_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ras_d   = ras_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    mis_d   = 1'b0;

    if (!start_i) begin
      pc_d    = RESET_VEC;
      valid_d = 1'b0;
      ptr_d   = '0;
      cnt_d   = '0;
    end else if (exc_i) begin
      pc_d    = exc_vec_i & ~LowMask;
      mis_d   = |(exc_vec_i & LowMask);
      valid_d = 1'b1;
      ptr_d   = '0;
      cnt_d   = '0;
    end else if (stall_i || !pcEnable_i) begin
      // Hold everything; pulses fall back to zero via defaults.
    end else if (ret_i) begin
      valid_d = 1'b1;
      if (cnt_q != '0) begin
        pc_d  = ras_q[top_idx];
        ptr_d = top_idx;
        cnt_d = cnt_q - CntW'(1);
      end else begin
        pc_d  = tgt_al;
        mis_d = tgt_mis;
        unf_d = 1'b1;
      end
    end else if (br_taken_i) begin
      valid_d = 1'b1;
      pc_d    = tgt_al;
      mis_d   = tgt_mis;
      if (call_i) begin
        // When full, ptr_q indexes the oldest entry, so the push overwrites it.
        ras_d[ptr_q] = seq_pc;
        ptr_d        = ptr_q + PtrW'(1);
        if (cnt_q == CntMax) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end else begin
      valid_d = 1'b1;
      pc_d    = seq_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      mis_q   <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CntMax);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      mis_q   <= mis_d;
      ras_q   <= ras_d;
    end
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = valid_q;
  assign ras_empty_o = empty_q;
  assign ras_full_o  = full_q;
  assign ras_ovf_o   = ovf_q;
  assign ras_unf_o   = unf_q;
  assign misalign_o  = mis_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed vector bench for pc_unit_ras with default parameters.
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, en, exc, br, call, ret;
  logic [31:0] evec, tgt;
  logic [31:0] pc;
  logic        valid, empty, full, ovf, unf, mis;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_unit_ras dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start),
    .stall_i     (stall),
    .pcEnable_i  (en),
    .exc_i       (exc),
    .exc_vec_i   (evec),
    .br_taken_i  (br),
    .br_target_i (tgt),
    .call_i      (call),
    .ret_i       (ret),
    .pc_o        (pc),
    .pc_valid_o  (valid),
    .ras_empty_o (empty),
    .ras_full_o  (full),
    .ras_ovf_o   (ovf),
    .ras_unf_o   (unf),
    .misalign_o  (mis)
  );

  typedef struct {
    logic        start, stall, en, exc;
    logic [31:0] evec;
    logic        br;
    logic [31:0] tgt;
    logic        call, ret;
    logic [31:0] pc;
    logic        valid, empty, full, ovf, unf, mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, sl, e, ex, input logic [31:0] ev, input logic b,
                     input logic [31:0] tg, input logic ca, re, input logic [31:0] p,
                     input logic va, em, fu, ov, un, mi);
    vec_t v;
    v = '{st, sl, e, ex, ev, b, tg, ca, re, p, va, em, fu, ov, un, mi};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] p, input logic va, em, fu,
                         input logic ov, un, mi);
    chk({tag, ".pc"}, pc, p);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, va});
    chk({tag, ".empty"}, {31'd0, empty}, {31'd0, em});
    chk({tag, ".full"}, {31'd0, full}, {31'd0, fu});
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, ov});
    chk({tag, ".unf"}, {31'd0, unf}, {31'd0, un});
    chk({tag, ".mis"}, {31'd0, mis}, {31'd0, mi});
  endtask

  task automatic drive(input logic st, sl, e, ex, input logic [31:0] ev, input logic b,
                       input logic [31:0] tg, input logic ca, re);
    start = st; stall = sl; en = e; exc = ex; evec = ev;
    br = b; tgt = tg; call = ca; ret = re;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #23;
    chk_all("reset", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //   st sl en ex evec     br tgt          ca re  pc           va em fu ov un mi
    add(1, 0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h4,        1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h8,        1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'hC,        1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h10,       1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   1, 32'h20,       1, 0, 32'h20,       1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 32'h0,   1, 32'h999,      0, 0, 32'h20,       1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 32'h0,   1, 32'h999,      0, 0, 32'h20,       1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,   1, 32'h999,      1, 0, 32'h20,       1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 32'h80,  1, 32'h999,      0, 0, 32'h80,       1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 32'h43,  0, 32'h0,        0, 0, 32'h40,       1, 1, 0, 0, 0, 1);
    add(1, 0, 1, 0, 32'h0,   1, 32'h100,      0, 0, 32'h100,      1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   1, 32'h200,      1, 0, 32'h200,      1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   1, 32'h777,      1, 1, 32'h104,      1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   1, 32'h10,       0, 0, 32'h10,       1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   1, 32'h20,       1, 0, 32'h20,       1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   1, 32'h30,       1, 0, 32'h30,       1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   1, 32'h40,       1, 0, 32'h40,       1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   1, 32'h50,       1, 0, 32'h50,       1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   1, 32'h60,       1, 0, 32'h60,       1, 0, 1, 1, 0, 0);
    add(1, 0, 1, 0, 32'h0,   0, 32'h999,      0, 1, 32'h54,       1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   0, 32'h999,      0, 1, 32'h44,       1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   0, 32'h999,      0, 1, 32'h34,       1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   0, 32'h999,      0, 1, 32'h24,       1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   0, 32'h300,      0, 1, 32'h300,      1, 1, 0, 0, 1, 0);
    add(1, 0, 1, 0, 32'h0,   0, 32'h301,      0, 1, 32'h300,      1, 1, 0, 0, 1, 1);
    add(1, 0, 1, 0, 32'h0,   0, 32'h500,      1, 0, 32'h304,      1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   1, 32'h203,      0, 0, 32'h200,      1, 1, 0, 0, 0, 1);
    add(1, 0, 1, 0, 32'h0,   1, 32'h204,      1, 0, 32'h204,      1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 32'h80,  1, 32'h900,      0, 0, 32'h0,        0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   0, 32'h10,       0, 1, 32'h10,       1, 1, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stall, vecs[i].en, vecs[i].exc, vecs[i].evec,
            vecs[i].br, vecs[i].tgt, vecs[i].call, vecs[i].ret);
      @(posedge clk); #1;
      chk_all($sformatf("v%0d", i), vecs[i].pc, vecs[i].valid, vecs[i].empty,
              vecs[i].full, vecs[i].ovf, vecs[i].unf, vecs[i].mis);
    end

    // Two-deep call chain, then asynchronous reset mid-cycle.
    drive(1, 0, 1, 0, 32'h0, 1, 32'h500, 1, 0);
    @(posedge clk); #1;
    chk_all("call1", 32'h500, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 32'h0, 1, 32'h600, 1, 0);
    @(posedge clk); #1;
    chk_all("call2", 32'h600, 1, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 1, 0, 32'h0, 0, 32'h40, 0, 1);
    @(posedge clk); #1;
    chk_all("post_rst_ret", 32'h40, 1, 1, 0, 0, 1, 0);
    drive(1, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
    @(posedge clk); #1;
    chk_all("unf_one_cycle", 32'h44, 1, 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
